// File: rtl/eth_line_lb_arbiter_if.sv
// eth_line_lb_arbiter_if: host, loopback and line-side XGMII stream handshakes
interface eth_line_lb_arbiter_if;
  logic        host_valid;
  logic [71:0] host_data;
  logic        host_ready;
  logic        lb_valid;
  logic [71:0] lb_data;
  logic        lb_ready;
  logic        out_valid;
  logic [71:0] out_data;
  logic        out_ready;
  modport master (
    output host_valid, host_data, lb_valid, lb_data, out_ready,
    input  host_ready, lb_ready, out_valid, out_data
  );
  modport slave (
    input  host_valid, host_data, lb_valid, lb_data, out_ready,
    output host_ready, lb_ready, out_valid, out_data
  );
endinterface

// File: rtl/eth_line_lb_arbiter.sv
// eth_line_lb_arbiter: frame-boundary host/loopback XGMII selector with idle gap at each switchover
module eth_line_lb_arbiter #(
  parameter int GAP_WORDS = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lb_enable,
  eth_line_lb_arbiter_if.slave bus,
  output logic                 lb_active,
  output logic [CNT_W-1:0]     switch_count,
  output logic [CNT_W-1:0]     host_drop_count
);
  typedef enum logic [2:0] {HOST_IDLE, HOST_FRAME, LB_IDLE, LB_FRAME, GAP} state_t;
  localparam logic [71:0] IDLE = 72'hFF_0707070707070707;
  localparam logic [3:0]  GW   = 4'(GAP_WORDS);
  state_t      state, state_nx;
  logic        gap_lb;
  logic [3:0]  gap_cnt;
  logic        mismatch, sel_lb, idle_st, in_gap, beat, gap_done, tgt, drop_inc;
  logic [71:0] cur;
  function automatic logic is_sop(input logic [71:0] w);
    return w[64] && w[7:0] == 8'hFB;
  endfunction
  function automatic logic is_eop(input logic [71:0] w);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 8; i++) r = r | (w[64+i] && w[8*i +: 8] == 8'hFD);
    return r;
  endfunction
  assign mismatch       = lb_enable != lb_active;
  assign sel_lb         = state == LB_IDLE || state == LB_FRAME;
  assign idle_st        = state == HOST_IDLE || state == LB_IDLE;
  assign in_gap         = state == GAP || (idle_st && mismatch);
  assign cur            = sel_lb ? bus.lb_data : bus.host_data;
  assign bus.out_valid  = in_gap || (sel_lb ? bus.lb_valid : bus.host_valid);
  assign bus.out_data   = in_gap ? IDLE : cur;
  assign bus.host_ready = !in_gap && (sel_lb || bus.out_ready);
  assign bus.lb_ready   = !in_gap && (!sel_lb || bus.out_ready);
  assign beat           = bus.out_valid && bus.out_ready;
  assign tgt            = state == GAP ? gap_lb : lb_enable;
  assign gap_done       = in_gap && beat && (gap_cnt + 4'd1 == GW);
  assign drop_inc       = sel_lb && bus.host_valid && bus.host_ready && is_sop(bus.host_data);
  always_comb begin
    state_nx = state;
    if (in_gap) state_nx = gap_done ? (tgt ? LB_IDLE : HOST_IDLE) : GAP;
    else if (beat && idle_st && is_sop(cur) && !is_eop(cur)) state_nx = sel_lb ? LB_FRAME : HOST_FRAME;
    else if (beat && !idle_st && is_eop(cur)) state_nx = sel_lb ? LB_IDLE : HOST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= HOST_IDLE;
      lb_active       <= 1'b0;
      gap_lb          <= 1'b0;
      gap_cnt         <= 4'd0;
      switch_count    <= '0;
      host_drop_count <= '0;
    end else begin
      state <= state_nx;
      if (state != GAP) gap_lb <= lb_enable;
      if (in_gap && beat) gap_cnt <= gap_done ? 4'd0 : gap_cnt + 4'd1;
      if (gap_done) lb_active <= tgt;
      if (gap_done && switch_count != '1) switch_count <= switch_count + CNT_W'(1);
      if (drop_inc && host_drop_count != '1) host_drop_count <= host_drop_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_eth_line_lb_arbiter.sv
// tb_eth_line_lb_arbiter: directed checks of switchover, discard, backpressure and reset behaviour
module tb_eth_line_lb_arbiter;
  localparam logic [71:0] IDLE = 72'hFF_0707070707070707;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lb_enable = 1'b0;
  logic        lb_active;
  logic [15:0] switch_count, host_drop_count;
  int          n_chk = 0;
  int          n_fail = 0;
  eth_line_lb_arbiter_if bus();
  eth_line_lb_arbiter dut (
    .clk(clk), .reset(reset), .lb_enable(lb_enable), .bus(bus),
    .lb_active(lb_active), .switch_count(switch_count), .host_drop_count(host_drop_count)
  );
  always #5 clk = ~clk;
  function automatic logic [71:0] dw(input logic [7:0] tag, input logic [7:0] n);
    return {8'h00, {7{tag}}, n};
  endfunction
  function automatic logic [71:0] sop(input logic [7:0] tag);
    return {8'h01, {7{tag}}, 8'hFB};
  endfunction
  function automatic logic [71:0] eop(input logic [7:0] tag);
    return {8'hF8, 32'h07070707, 8'hFD, {3{tag}}};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.host_valid = 1'b1;
    bus.host_data  = IDLE;
    bus.lb_valid   = 1'b1;
    bus.lb_data    = dw(8'hB0, 8'h01);
    bus.out_ready  = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_out_data", bus.out_data, IDLE);
    chk("rst_out_valid", bus.out_valid, 1'b1);
    chk("rst_host_ready", bus.host_ready, 1'b1);
    chk("rst_lb_ready", bus.lb_ready, 1'b1);
    chk("rst_lb_active", lb_active, 1'b0);
    chk("rst_switch", switch_count, 16'd0);
    chk("rst_drop", host_drop_count, 16'd0);
    bus.out_ready = 1'b0;
    #1;
    chk("rst_host_ready_bp", bus.host_ready, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.host_data = sop(8'hA0);
    #1;
    chk("frm_sop", bus.out_data, sop(8'hA0));
    tick();
    lb_enable = 1'b1;
    bus.host_data = dw(8'hA0, 8'h02);
    #1;
    chk("frm_w2", bus.out_data, dw(8'hA0, 8'h02));
    chk("frm_w2_ready", bus.host_ready, 1'b1);
    for (int k = 3; k < 8; k++) begin
      tick();
      bus.host_data = dw(8'hA0, 8'(k));
      #1;
      chk("frm_wk", bus.out_data, dw(8'hA0, 8'(k)));
    end
    tick();
    bus.host_data = eop(8'hA0);
    #1;
    chk("frm_eop", bus.out_data, eop(8'hA0));
    tick();
    bus.host_data = dw(8'hA0, 8'h09);
    #1;
    chk("gap1_data", bus.out_data, IDLE);
    chk("gap1_host_ready", bus.host_ready, 1'b0);
    chk("gap1_lb_ready", bus.lb_ready, 1'b0);
    tick();
    chk("gap2_data", bus.out_data, IDLE);
    chk("gap2_lb_active", lb_active, 1'b0);
    tick();
    chk("lb_first", bus.out_data, dw(8'hB0, 8'h01));
    chk("lb_active_up", lb_active, 1'b1);
    chk("switch_1", switch_count, 16'd1);
    chk("lb_host_ready", bus.host_ready, 1'b1);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        bus.host_data = k == 0 ? sop(8'hA1) : k == 1 ? dw(8'hA1, 8'h10) : eop(8'hA1);
        bus.lb_data = dw(8'hB2, 8'(f * 3 + k));
        #1;
        chk("drop_host_ready", bus.host_ready, 1'b1);
        chk("drop_out", bus.out_data, dw(8'hB2, 8'(f * 3 + k)));
      end
    end
    tick();
    chk("drop_count", host_drop_count, 16'd3);
    lb_enable = 1'b0;
    bus.out_ready = 1'b0;
    bus.host_data = dw(8'hA2, 8'h01);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_data", bus.out_data, IDLE);
      chk("bp_lb_ready", bus.lb_ready, 1'b0);
      tick();
    end
    chk("bp_still_lb", lb_active, 1'b1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_beat1", bus.out_data, IDLE);
    tick();
    chk("bp_beat2", bus.out_data, IDLE);
    tick();
    chk("bp_host_back", bus.out_data, dw(8'hA2, 8'h01));
    chk("bp_lb_active", lb_active, 1'b0);
    chk("switch_2", switch_count, 16'd2);
    lb_enable = 1'b1;
    #1;
    chk("tg_gap_a", bus.out_data, IDLE);
    tick();
    lb_enable = 1'b0;
    #1;
    chk("tg_gap_b", bus.out_data, IDLE);
    tick();
    chk("tg_lb_active", lb_active, 1'b1);
    chk("tg_switch_3", switch_count, 16'd3);
    chk("tg_regap", bus.out_data, IDLE);
    tick();
    chk("tg_regap2", bus.out_data, IDLE);
    tick();
    chk("tg_host", bus.out_data, dw(8'hA2, 8'h01));
    chk("tg_lb_off", lb_active, 1'b0);
    chk("tg_switch_4", switch_count, 16'd4);
    lb_enable = 1'b1;
    tick();
    tick();
    bus.lb_data = sop(8'hB3);
    #1;
    chk("rf_sop", bus.out_data, sop(8'hB3));
    tick();
    bus.lb_data = dw(8'hB3, 8'h05);
    #1;
    chk("rf_mid", bus.out_data, dw(8'hB3, 8'h05));
    tick();
    reset = 1'b1;
    lb_enable = 1'b0;
    bus.host_data = dw(8'hA4, 8'h07);
    tick();
    reset = 1'b0;
    #1;
    chk("rf_out", bus.out_data, dw(8'hA4, 8'h07));
    chk("rf_lb_ready", bus.lb_ready, 1'b1);
    chk("rf_lb_active", lb_active, 1'b0);
    chk("rf_switch", switch_count, 16'd0);
    chk("rf_drop", host_drop_count, 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
